blu_issue_stage: RTL

BLU_ISSUE_STAGE -- requirements
Module: blu_issue_stage

---
 rtl/blu_pkg.sv | 27 ++
 rtl/blu_op_fifo.sv | 55 +++++
 rtl/blu_issue_stage.sv | 129 ++++++++++++
 3 files changed

// File: rtl/blu_pkg.sv
// Shared definitions for the butterfly issue stage.
//   blu_state_e    : issue-stage FSM state
//   blu_op_t       : operand triple {data1, data2, zeta} at the default width
//   BLU_DATA_WIDTH : default coefficient-pair width
//   blu_op_width() : packed width of one operand triple for a given data width
package blu_pkg;

  localparam int BLU_DATA_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } blu_state_e;

  typedef struct packed {
    logic [BLU_DATA_WIDTH-1:0]   data1;
    logic [BLU_DATA_WIDTH-1:0]   data2;
    logic [BLU_DATA_WIDTH/2-1:0] zeta;
  } blu_op_t;

  // Queue entries carry two full-width operands plus a half-width twiddle.
  function automatic int blu_op_width(input int dw);
    return 2 * dw + dw / 2;
  endfunction

endpackage

// File: rtl/blu_op_fifo.sv
// Operand queue for the issue stage: a small FIFO of packed operand triples.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset (empties the queue)
//   push, wdata : write one entry (caller guarantees !full)
//   pop, rdata  : rdata always shows the head; pop advances it (caller guarantees !empty)
//   full, empty : occupancy flags, derived from registered state only
module blu_op_fifo
  import blu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = blu_op_width(BLU_DATA_WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;

  // Storage is not reset; occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/blu_issue_stage.sv
// Issue stage in front of a butterfly unit. A batch is opened with start_i and
// a non-zero batch_len_i; up to batch_len_i operand triples are accepted over
// a valid/ready handshake, queued, and issued one per cycle (unless stall_i)
// into registered outputs. The final issue raises last_o; one cycle later the
// FSM pulses done_o and returns to idle.
// Ports:
//   clk_i, reset_ni                      : clock, synchronous active-low reset
//   start_i, batch_len_i                 : batch start / length (idle only)
//   in_valid_i, in_ready_o               : upstream handshake
//   data1_i, data2_i, zeta_i             : incoming operand triple
//   stall_i                              : holds off issue while high
//   data1_o, data2_o, zeta_o             : registered operands (hold when idle)
//   out_valid_o, last_o                  : issue pulse / final issue of batch
//   busy_o, done_o                       : batch running / one-cycle done pulse
//   count_o                              : butterflies issued in this batch
module blu_issue_stage
  import blu_pkg::*;
#(
  parameter int DATA_WIDTH = BLU_DATA_WIDTH,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    start_i,
  input  logic [CNT_WIDTH-1:0]    batch_len_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [DATA_WIDTH-1:0]   data1_i,
  input  logic [DATA_WIDTH-1:0]   data2_i,
  input  logic [DATA_WIDTH/2-1:0] zeta_i,
  input  logic                    stall_i,
  output logic [DATA_WIDTH-1:0]   data1_o,
  output logic [DATA_WIDTH-1:0]   data2_o,
  output logic [DATA_WIDTH/2-1:0] zeta_o,
  output logic                    out_valid_o,
  output logic                    last_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [CNT_WIDTH-1:0]    count_o
);

  localparam int ZW   = DATA_WIDTH / 2;
  localparam int OP_W = blu_op_width(DATA_WIDTH);

  blu_state_e           state;
  logic [CNT_WIDTH-1:0] len_q;
  logic [CNT_WIDTH-1:0] acc_cnt;
  logic                 fifo_full, fifo_empty;
  logic                 accept, issue;
  logic [OP_W-1:0]      head;

  // Ready looks only at registered state (never at this cycle's pop), and
  // the accept bound keeps both counters within batch_len, so nothing wraps.
  assign in_ready_o = (state == ST_RUN) && !fifo_full && (acc_cnt < len_q);
  assign accept     = in_valid_i && in_ready_o;
  // The queue never holds more than the un-issued remainder of the batch,
  // so a non-empty queue in RUN always has a butterfly left to issue.
  assign issue      = (state == ST_RUN) && !fifo_empty && !stall_i;

  blu_op_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (OP_W)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (reset_ni),
    .push  (accept),
    .wdata ({data1_i, data2_i, zeta_i}),
    .pop   (issue),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state       <= ST_IDLE;
      len_q       <= '0;
      acc_cnt     <= '0;
      count_o     <= '0;
      data1_o     <= '0;
      data2_o     <= '0;
      zeta_o      <= '0;
      out_valid_o <= 1'b0;
      last_o      <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      out_valid_o <= 1'b0;
      last_o      <= 1'b0;
      done_o      <= 1'b0;

      if (accept) acc_cnt <= acc_cnt + 1'b1;

      if (issue) begin
        data1_o     <= head[OP_W-1 -: DATA_WIDTH];
        data2_o     <= head[ZW +: DATA_WIDTH];
        zeta_o      <= head[ZW-1:0];
        out_valid_o <= 1'b1;
        count_o     <= count_o + 1'b1;
        last_o      <= (count_o == len_q - 1'b1);
      end

      case (state)
        ST_IDLE: begin
          if (start_i && (batch_len_i != '0)) begin
            len_q   <= batch_len_i;
            acc_cnt <= '0;
            count_o <= '0;
            busy_o  <= 1'b1;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          // The final issue already happened on the previous edge, so done
          // follows the last_o cycle rather than overlapping it.
          if (count_o == len_q) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
